// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared widths, timeout default and FSM encodings for apb_req_arbiter
package apb_pkg;

  localparam int DEF_DATAWIDTH = 32;
  localparam int DEF_ADDRWIDTH = 8;
  localparam int DEF_TIMEOUT   = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting one past the pointer
module rr_arbiter
  import apb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDXW-1:0] idx
);

  function automatic logic [IDXW-1:0] wrap_add(input logic [IDXW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDXW'(s);
  endfunction

  // Walk from the farthest candidate to the nearest so the nearest set bit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[wrap_add(ptr, k)]) begin
        grant = '0;
        grant[wrap_add(ptr, k)] = 1'b1;
        idx = wrap_add(ptr, k);
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - round-robin APB master sharing one slave between NREQ requesters
module apb_req_arbiter
  import apb_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int ADDRWIDTH = DEF_ADDRWIDTH,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           req_write,
  input  logic [NREQ*ADDRWIDTH-1:0] req_addr,
  input  logic [NREQ*DATAWIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]           done,
  output logic [DATAWIDTH-1:0]      rdata,
  output logic                      err,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDRWIDTH-1:0]      PADDR,
  output logic [DATAWIDTH-1:0]      PWDATA,
  input  logic [DATAWIDTH-1:0]      PRDATA,
  input  logic                      PREADY
);

  localparam int IDXW = $clog2(NREQ);
  localparam int CNTW = $clog2(TIMEOUT);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

  state_t                 state, state_n;
  logic [IDXW-1:0]        ptr, ptr_n;
  logic [NREQ-1:0]        gsel, gsel_n;
  logic [CNTW-1:0]        cnt, cnt_n;
  logic                   psel_n, penable_n, pwrite_n, err_n;
  logic [ADDRWIDTH-1:0]   paddr_n;
  logic [DATAWIDTH-1:0]   pwdata_n, rdata_n;
  logic [NREQ-1:0]        done_n;
  logic [NREQ-1:0]        arb_grant;
  logic [IDXW-1:0]        arb_idx;

  rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_rr (
    .req   (req),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state   <= ST_IDLE;
      ptr     <= IDXW'(NREQ - 1);
      gsel    <= '0;
      cnt     <= '0;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
      done    <= '0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      gsel    <= gsel_n;
      cnt     <= cnt_n;
      PSEL    <= psel_n;
      PENABLE <= penable_n;
      PWRITE  <= pwrite_n;
      PADDR   <= paddr_n;
      PWDATA  <= pwdata_n;
      done    <= done_n;
      rdata   <= rdata_n;
      err     <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    gsel_n    = gsel;
    cnt_n     = cnt;
    psel_n    = PSEL;
    penable_n = PENABLE;
    pwrite_n  = PWRITE;
    paddr_n   = PADDR;
    pwdata_n  = PWDATA;
    rdata_n   = rdata;
    done_n    = '0;
    err_n     = 1'b0;
    case (state)
      ST_IDLE: begin
        psel_n    = 1'b0;
        penable_n = 1'b0;
        // The done cycle is spent in IDLE without arbitrating.
        if (done == '0 && |req) begin
          gsel_n   = arb_grant;
          ptr_n    = arb_idx;
          pwrite_n = req_write[arb_idx];
          paddr_n  = req_addr[arb_idx*ADDRWIDTH +: ADDRWIDTH];
          pwdata_n = req_wdata[arb_idx*DATAWIDTH +: DATAWIDTH];
          psel_n   = 1'b1;
          state_n  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_n     = '0;
        penable_n = 1'b1;
        state_n   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          done_n    = gsel;
          rdata_n   = PWRITE ? '0 : PRDATA;
          psel_n    = 1'b0;
          penable_n = 1'b0;
          state_n   = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          done_n    = gsel;
          err_n     = 1'b1;
          rdata_n   = '0;
          psel_n    = 1'b0;
          penable_n = 1'b0;
          state_n   = ST_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        psel_n    = 1'b0;
        penable_n = 1'b0;
        state_n   = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb/tb_apb_req_arbiter.sv - scoreboard bench for apb_req_arbiter with a randomized APB RAM slave
module tb_apb_req_arbiter;
  localparam int NREQ = 3, DW = 32, AW = 8, TIMEOUT = 16, NEVER = 999;

  typedef struct packed {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } cmd_t;

  logic PCLK = 1'b0, PRESET = 1'b1;
  logic [NREQ-1:0] req = '0, req_write = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ-1:0] done;
  logic [DW-1:0] rdata, PWDATA, PRDATA = '0;
  logic err, PSEL, PENABLE, PWRITE, PREADY = 1'b0;
  logic [AW-1:0] PADDR;

  int checks = 0, errors = 0;
  cmd_t cmd_q[NREQ][$];
  cmd_t exp_q[NREQ][$];
  int grant_log[$];
  logic [DW-1:0] ref_mem[256], slave_mem[256];
  logic [NREQ-1:0] busy = '0, drop_req = '0, req_prev = '0;
  int force_waits = -1;
  int last = NREQ - 1, cur = 0, waits = 0, acc_cnt = 0, exp_acc = 0, cyc = 0, last_done_cyc = -100;
  bit in_xfer = 0;
  logic [DW-1:0] rd_hold = '0;

  apb_req_arbiter #(.NREQ(NREQ), .DATAWIDTH(DW), .ADDRWIDTH(AW), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req(req), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .done(done), .rdata(rdata), .err(err), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int lst);
    for (int k = 1; k <= NREQ; k++)
      if (r[(lst + k) % NREQ]) return (lst + k) % NREQ;
    return -1;
  endfunction

  function automatic int pick_waits();
    case ($urandom_range(0, 9))
      0, 1, 2: return 0;
      3, 4:    return 1;
      5:       return 2;
      6:       return int'($urandom_range(3, TIMEOUT - 2));
      7:       return TIMEOUT - 1;
      8:       return TIMEOUT;
      default: return NEVER;
    endcase
  endfunction

  function automatic int qsum();
    int s = 0;
    for (int i = 0; i < NREQ; i++) s += cmd_q[i].size() + exp_q[i].size();
    return s;
  endfunction

  task automatic push_cmd(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_t c;
    c.w = w; c.a = a; c.d = d;
    cmd_q[i].push_back(c);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    repeat (2) @(posedge PCLK);
    while (n < budget && (busy != '0 || qsum() != 0 || PSEL)) begin
      @(posedge PCLK);
      n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL drain_timeout: still busy after %0d cycles, expected idle", budget);
    end
    repeat (3) @(posedge PCLK);
  endtask

  // Requesters: raise req with a queued command, hold it until done, re-raise at once if more queued.
  always begin : requesters
    cmd_t c;
    @(posedge PCLK); #1;
    if (PRESET) begin
      req = '0; busy = '0; drop_req = '0;
      for (int i = 0; i < NREQ; i++) begin cmd_q[i].delete(); exp_q[i].delete(); end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (done[i]) begin req[i] = 1'b0; busy[i] = 1'b0; end
        if (drop_req[i] && req[i] && PSEL && !PENABLE) begin req[i] = 1'b0; drop_req[i] = 1'b0; end
        if (!busy[i] && cmd_q[i].size() > 0) begin
          c = cmd_q[i].pop_front();
          req_write[i] = c.w;
          req_addr[i*AW +: AW] = c.a;
          req_wdata[i*DW +: DW] = c.d;
          req[i] = 1'b1; busy[i] = 1'b1;
          exp_q[i].push_back(c);
        end
      end
    end
  end

  // Monitor plus RAM slave: predicts grant order, wait states, done/err/rdata.
  always begin : monitor
    int g;
    cmd_t c;
    logic tmo;
    logic [DW-1:0] exp_rd;
    logic [NREQ-1:0] oh;
    @(negedge PCLK);
    cyc++;
    if (PRESET) begin
      last = NREQ - 1; in_xfer = 0; rd_hold = '0; last_done_cyc = -100;
      PREADY = 1'($urandom_range(0, 1));
    end else begin
      if (done != '0) begin
        if (!in_xfer || exp_q[cur].size() == 0) begin
          check("spurious_done", done, '0);
        end else begin
          c = exp_q[cur].pop_front();
          tmo = (waits >= TIMEOUT);
          exp_rd = (tmo || c.w) ? '0 : ref_mem[c.a];
          oh = '0; oh[cur] = 1'b1;
          check("done_onehot", done, oh);
          check("err", err, tmo);
          check("rdata", rdata, exp_rd);
          check("access_cycles", acc_cnt, exp_acc);
          check("bus_idle_in_done", {PSEL, PENABLE}, 2'b00);
          if (!tmo && c.w) ref_mem[c.a] = c.d;
          rd_hold = exp_rd; in_xfer = 0; last_done_cyc = cyc;
        end
      end else begin
        check("err_idle", err, 1'b0);
        check("rdata_hold", rdata, rd_hold);
        if (in_xfer && !PSEL) begin
          check("psel_dropped", PSEL, 1'b1);
          in_xfer = 0;
        end
      end
      if (PSEL && !PENABLE) begin
        g = rr_pick(req_prev, last);
        check("setup_single_cycle", in_xfer, 1'b0);
        check("setup_gap", (cyc - last_done_cyc) >= 2, 1'b1);
        if (g < 0 || exp_q[(g < 0) ? 0 : g].size() == 0) begin
          check("setup_without_req", PSEL, 1'b0);
        end else begin
          c = exp_q[g][0];
          check("paddr", PADDR, c.a);
          check("pwrite", PWRITE, c.w);
          check("pwdata", PWDATA, c.d);
          grant_log.push_back(g);
          last = g; cur = g; in_xfer = 1; acc_cnt = 0;
          waits = (force_waits >= 0) ? force_waits : pick_waits();
          exp_acc = (waits < TIMEOUT) ? waits + 1 : TIMEOUT;
        end
        PREADY = 1'($urandom_range(0, 1));
        PRDATA = $urandom;
      end else if (PSEL && PENABLE) begin
        PREADY = in_xfer ? (acc_cnt >= waits) : 1'b1;
        PRDATA = slave_mem[PADDR];
        if (PREADY && PWRITE) slave_mem[PADDR] = PWDATA;
        acc_cnt++;
        if (in_xfer && acc_cnt > exp_acc) begin
          check("access_overrun", acc_cnt, exp_acc);
          in_xfer = 0;
        end
      end else begin
        PREADY = 1'($urandom_range(0, 1));
        PRDATA = $urandom;
      end
    end
    req_prev = req;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [DW-1:0] d5;
    int n;
    for (int i = 0; i < 256; i++) begin ref_mem[i] = '0; slave_mem[i] = '0; end
    PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK); #1;
    check("rst_psel", PSEL, 1'b0);
    check("rst_penable", PENABLE, 1'b0);
    check("rst_pwrite", PWRITE, 1'b0);
    check("rst_paddr", PADDR, '0);
    check("rst_pwdata", PWDATA, '0);
    check("rst_done", done, '0);
    check("rst_rdata", rdata, '0);
    check("rst_err", err, 1'b0);
    PRESET = 1'b0;

    force_waits = 0; grant_log.delete();
    push_cmd(0, 1'b1, 8'h10, 32'hDEADBEEF);
    wait_idle(100);
    check("write_grants", grant_log.size(), 1);
    check("write_slave_mem", slave_mem[8'h10], 32'hDEADBEEF);

    force_waits = 2;
    push_cmd(1, 1'b0, 8'h10, $urandom);
    wait_idle(100);
    check("readback_rdata", rdata, 32'hDEADBEEF);

    force_waits = 0; grant_log.delete();
    for (int k = 0; k < 2; k++) begin
      push_cmd(0, 1'b1, 8'(k + 1), $urandom);
      push_cmd(1, 1'b1, 8'(k + 3), $urandom);
    end
    wait_idle(200);
    check("contend_count", grant_log.size(), 4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++) check("contend_order", grant_log[k], k % 2);

    force_waits = NEVER;
    push_cmd(2, 1'b0, 8'h10, $urandom);
    wait_idle(100);
    check("timeout_rdata", rdata, '0);
    force_waits = 0;
    push_cmd(2, 1'b0, 8'h10, $urandom);
    wait_idle(100);
    check("after_timeout_rdata", rdata, 32'hDEADBEEF);

    force_waits = 1; grant_log.delete(); d5 = $urandom;
    drop_req[0] = 1'b1;
    push_cmd(0, 1'b1, 8'h30, d5);
    wait_idle(100);
    repeat (10) @(posedge PCLK);
    check("drop_single_grant", grant_log.size(), 1);
    check("drop_slave_mem", slave_mem[8'h30], d5);

    force_waits = -1;
    for (int t = 0; t < 400; t++) begin
      @(posedge PCLK);
      for (int i = 0; i < NREQ; i++)
        if (cmd_q[i].size() < 2 && $urandom_range(0, 4) == 0)
          push_cmd(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom);
    end
    wait_idle(5000);

    force_waits = NEVER;
    push_cmd(2, 1'b0, 8'h05, $urandom);
    n = 0;
    do begin @(negedge PCLK); n++; end while (!(PSEL && PENABLE) && n < 100);
    check("reach_access", PSEL && PENABLE, 1'b1);
    #2 PRESET = 1'b1;
    @(negedge PCLK); #1;
    check("midrst_psel", PSEL, 1'b0);
    check("midrst_penable", PENABLE, 1'b0);
    check("midrst_done", done, '0);
    check("midrst_err", err, 1'b0);
    check("midrst_paddr", PADDR, '0);
    check("midrst_rdata", rdata, '0);
    PRESET = 1'b0;
    force_waits = 0; grant_log.delete();
    push_cmd(1, 1'b0, 8'h10, $urandom);
    push_cmd(0, 1'b0, 8'h10, $urandom);
    wait_idle(100);
    check("postrst_count", grant_log.size(), 2);
    check("postrst_first", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
    check("postrst_second", (grant_log.size() > 1) ? grant_log[1] : -1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
